// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_sb
//  Purpose  : Multi-read-port register file with a per-register pending-write
//             scoreboard. Reads are combinational, with optional same-cycle
//             write-to-read forwarding. Entry 0 can optionally be hardwired
//             to zero. Decode uses the pending bits to detect RAW hazards on
//             registers whose writeback is still outstanding.
//
//  Ports    : clk          rising-edge clock
//             rst_n        asynchronous active-low reset
//             wr_enable    writeback strobe
//             wr_addr      writeback register index
//             wr_data      writeback data
//             iss_enable   issue strobe, marks iss_addr as pending
//             iss_addr     destination register of the issued instruction
//             rd_addr      packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//             rd_data      packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//             rd_pending   per-port outstanding-writeback flag
//             any_pending  OR of all pending bits (registered state only)
//
//  Revision : 1.0  initial release
// ============================================================================
module register_file_sb #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 32,
  parameter  int NUM_RD     = 2,
  parameter  int BYPASS     = 1,
  parameter  int ZERO_REG0  = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_enable,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         iss_enable,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_pending,
  output logic                         any_pending
);

  // Every encodable address gets one bit saying whether it names a real,
  // writable register. Out-of-range addresses (non-power-of-2 DEPTH) and the
  // hardwired zero entry are both cleared here, so a single lookup answers
  // "does this address take part in writes, issues, reads and bypass".
  localparam int c_slots = 1 << ADDR_WIDTH;

  function automatic logic [c_slots-1:0] f_valid_mask();
    logic [c_slots-1:0] m;
    for (int i = 0; i < c_slots; i++) begin
      m[i] = (i < DEPTH) && !((ZERO_REG0 != 0) && (i == 0));
    end
    return m;
  endfunction

  localparam logic [c_slots-1:0] c_valid_mask = f_valid_mask();

  // --------------------------------------------------------------------------
  // State: register contents and pending bits
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];
  logic [DEPTH-1:0]      r_pending;
  logic [DEPTH-1:0]      w_pending_nxt;

  logic w_wr_ok;
  logic w_iss_ok;

  assign w_wr_ok  = wr_enable  && c_valid_mask[wr_addr];
  assign w_iss_ok = iss_enable && c_valid_mask[iss_addr];

  // Issue takes priority over writeback on the same entry: the newly issued
  // producer is still outstanding even though the older result lands now.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_iss_ok && (iss_addr == ADDR_WIDTH'(i))) begin
        w_pending_nxt[i] = 1'b1;
      end else if (w_wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      // Per-entry compare keeps the write index inside the array even for
      // addresses beyond DEPTH.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
          r_regs[i] <= wr_data;
        end
      end
      r_pending <= w_pending_nxt;
    end
  end

  assign any_pending = |r_pending;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_ok;
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_pend;

      assign w_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_ok   = c_valid_mask[w_addr];
      // A forwarded value is the newest one, so its pending flag is masked.
      assign w_hit  = (BYPASS != 0) && w_wr_ok && (wr_addr == w_addr);

      always_comb begin
        w_data = '0;
        w_pend = 1'b0;
        // The reset gate stops a write strobe held during reset from being
        // forwarded onto the read data.
        if (rst_n && w_ok) begin
          if (w_hit) begin
            w_data = wr_data;
          end else begin
            w_data = r_regs[w_addr];
            w_pend = r_pending[w_addr];
          end
        end
      end

      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign rd_pending[k]                       = w_pend;
    end
  endgenerate

endmodule
`default_nettype wire
